// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial link layer.
//   NumCredits        peer receive-buffer depth, also the reset send-credit count
//   NumReq            number of AXI channel packetizers feeding the scheduler
//   ForceCreditThresh pending-return level that forces a credit-only packet
//   credit_t          holds 0..NumCredits inclusive
//   tag_e             packet type carried in the link header
//   link_state_e      send-scheduler state encoding
package serial_link_pkg;

  localparam int unsigned NumCredits        = 8;
  localparam int unsigned NumReq            = 4;
  localparam int unsigned CreditW           = $clog2(NumCredits) + 1;
  localparam int unsigned ReqIdxW           = $clog2(NumReq);
  localparam int unsigned ForceCreditThresh = NumCredits - 1;

  typedef logic [CreditW-1:0] credit_t;

  // Data tags are ordered so that requester index i maps to TagAW + i.
  typedef enum logic [2:0] {
    TagAW   = 3'd0,
    TagW    = 3'd1,
    TagAR   = 3'd2,
    TagR    = 3'd3,
    TagIdle = 3'd4
  } tag_e;

  typedef logic [0:0] link_state_e;
  localparam link_state_e LinkSendIdle = 1'b0;
  localparam link_state_e LinkSendBusy = 1'b1;

  // Header fields of the packet currently offered to the PHY.
  typedef struct packed {
    tag_e              tag;
    logic [NumReq-1:0] sel;
    credit_t           credit;
  } pkt_hdr_t;

  // Requester index to data tag.
  function automatic tag_e reqTag(input logic [ReqIdxW-1:0] idx);
    return tag_e'(3'(idx));
  endfunction

endpackage

// File: rtl/serial_link_credit_sched.sv
// Link-layer send scheduler: round-robin arbitration of the AW/W/AR/R
// packetizers onto one packet stream toward the PHY, gated by send credits.
// Every packet piggybacks the credits owed to the peer; when owed credits pile
// up and no data packet can go, a credit-only (TagIdle) packet is sent.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i          per-requester packet pending (held until req_ready_o)
//   req_ready_o          one-hot, high in the handshake cycle of the granted requester
//   pkt_valid_o/ready_i  packet handshake with the PHY send path
//   pkt_tag_o            TagAW..TagR for data, TagIdle for credit-only
//   pkt_sel_o            one-hot payload-mux select, zero for credit-only
//   pkt_credit_o         credits returned to the peer inside this packet
//   rcv_credit_valid_i   a received packet carried a credit field
//   rcv_credit_i         credits returned by the peer
//   consumed_i           local receive buffer freed one entry
//   credits_avail_o      current send credits
//   credit_err_o         sticky: peer returned more credits than it could own
module serial_link_credit_sched
  import serial_link_pkg::*;
#(
  parameter int unsigned ForceThresh = ForceCreditThresh
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i,
  output tag_e              pkt_tag_o,
  output logic [NumReq-1:0] pkt_sel_o,
  output credit_t           pkt_credit_o,
  input  logic              rcv_credit_valid_i,
  input  credit_t           rcv_credit_i,
  input  logic              consumed_i,
  output credit_t           credits_avail_o,
  output logic              credit_err_o
);

  localparam int unsigned SumW = CreditW + 1;
  localparam int unsigned IdxW = ReqIdxW;

  link_state_e     stateQ, stateD;
  logic            validQ, validD;
  pkt_hdr_t        hdrQ, hdrD;
  logic [IdxW-1:0] idxQ, idxD;
  logic [IdxW-1:0] rrPtrQ, rrPtrD;
  credit_t         sendCntQ, sendCntD;
  credit_t         retCntQ, retCntD;
  logic            errQ, errD;

  logic              handshake;
  logic              dataHs;
  credit_t           sendEff;
  credit_t           retEff;
  logic [IdxW-1:0]   searchBase;
  logic [NumReq-1:0] candMask;
  logic              found;
  logic [IdxW-1:0]   foundIdx;
  logic [SumW-1:0]   sendSum;
  logic [SumW-1:0]   retSum;

  assign handshake = (stateQ == LinkSendBusy) && pkt_ready_i;
  assign dataHs    = handshake && (hdrQ.tag != TagIdle);

  assign req_ready_o     = handshake ? hdrQ.sel : '0;
  assign pkt_valid_o     = validQ;
  assign pkt_tag_o       = hdrQ.tag;
  assign pkt_sel_o       = hdrQ.sel;
  assign pkt_credit_o    = hdrQ.credit;
  assign credits_avail_o = sendCntQ;
  assign credit_err_o    = errQ;

  // Round-robin candidate search. Credits for a new offer exclude the packet
  // leaving this cycle; credits arriving this cycle only count from next cycle.
  always_comb begin
    sendEff    = sendCntQ - credit_t'(dataHs);
    retEff     = retCntQ - (handshake ? hdrQ.credit : '0);
    // NumReq is a power of two, so the pointer increment wraps on its own.
    searchBase = dataHs ? idxQ + IdxW'(1) : rrPtrQ;
    candMask   = req_valid_i;
    // The requester being granted now still shows valid for this packet.
    if (dataHs) candMask[idxQ] = 1'b0;
    found    = 1'b0;
    foundIdx = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!found && candMask[searchBase + IdxW'(k)]) begin
        found    = 1'b1;
        foundIdx = searchBase + IdxW'(k);
      end
    end
  end

  // Next-state, offer registration and credit bookkeeping.
  always_comb begin
    stateD   = stateQ;
    validD   = validQ;
    hdrD     = hdrQ;
    idxD     = idxQ;
    rrPtrD   = rrPtrQ;
    errD     = errQ;
    sendSum  = SumW'(sendEff) + (rcv_credit_valid_i ? SumW'(rcv_credit_i) : '0);
    retSum   = SumW'(retEff) + SumW'(consumed_i);
    sendCntD = credit_t'(sendSum);
    retCntD  = credit_t'(retSum);

    // A new offer is chosen only when nothing is stalled on the PHY.
    if ((stateQ == LinkSendIdle) || handshake) begin
      if ((sendEff != '0) && found) begin
        stateD      = LinkSendBusy;
        validD      = 1'b1;
        hdrD.tag    = reqTag(foundIdx);
        hdrD.sel    = NumReq'(1) << foundIdx;
        hdrD.credit = retEff;
        idxD        = foundIdx;
      end else if (retEff >= credit_t'(ForceThresh)) begin
        stateD      = LinkSendBusy;
        validD      = 1'b1;
        hdrD.tag    = TagIdle;
        hdrD.sel    = '0;
        hdrD.credit = retEff;
      end else begin
        stateD = LinkSendIdle;
        validD = 1'b0;
      end
    end

    if (dataHs) rrPtrD = idxQ + IdxW'(1);

    // Peer can never legitimately own more than its buffer depth.
    if (sendSum > SumW'(NumCredits)) begin
      sendCntD = credit_t'(NumCredits);
      errD     = 1'b1;
    end

    // Owed credits cannot exceed our own buffer depth.
    if (retSum > SumW'(NumCredits)) retCntD = credit_t'(NumCredits);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateQ      <= LinkSendIdle;
      validQ      <= 1'b0;
      hdrQ.tag    <= TagIdle;
      hdrQ.sel    <= '0;
      hdrQ.credit <= '0;
      idxQ        <= '0;
      rrPtrQ      <= '0;
      sendCntQ    <= credit_t'(NumCredits);
      retCntQ     <= '0;
      errQ        <= 1'b0;
    end else begin
      stateQ   <= stateD;
      validQ   <= validD;
      hdrQ     <= hdrD;
      idxQ     <= idxD;
      rrPtrQ   <= rrPtrD;
      sendCntQ <= sendCntD;
      retCntQ  <= retCntD;
      errQ     <= errD;
    end
  end

endmodule

// File: tb/tb_serial_link_credit_sched.sv
// Scoreboard bench for serial_link_credit_sched: a cycle reference model
// predicts status and accepted packets, a negedge monitor compares.
module tb_serial_link_credit_sched;
  import serial_link_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq-1:0] req_ready_o;
  logic              pkt_valid_o;
  logic              pkt_ready_i;
  tag_e              pkt_tag_o;
  logic [NumReq-1:0] pkt_sel_o;
  credit_t           pkt_credit_o;
  logic              rcv_credit_valid_i;
  credit_t           rcv_credit_i;
  logic              consumed_i;
  credit_t           credits_avail_o;
  logic              credit_err_o;

  always #5 clk_i = ~clk_i;

  serial_link_credit_sched dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .pkt_valid_o        (pkt_valid_o),
    .pkt_ready_i        (pkt_ready_i),
    .pkt_tag_o          (pkt_tag_o),
    .pkt_sel_o          (pkt_sel_o),
    .pkt_credit_o       (pkt_credit_o),
    .rcv_credit_valid_i (rcv_credit_valid_i),
    .rcv_credit_i       (rcv_credit_i),
    .consumed_i         (consumed_i),
    .credits_avail_o    (credits_avail_o),
    .credit_err_o       (credit_err_o)
  );

  typedef struct {
    int          tag;
    logic [3:0]  sel;
    int          credit;
  } pkt_exp_t;

  typedef struct {
    bit valid;
    int send;
    bit err;
  } stat_exp_t;

  pkt_exp_t  expQ[$];
  stat_exp_t statQ[$];
  pkt_exp_t  monPkt;
  stat_exp_t monStat;
  int nChecks = 0;
  int nPass   = 0;

  // Reference model: an outstanding offer (requester index or -1 for
  // credit-only), the credits it carries, and the two credit pools.
  bit                mBusy;
  int                mReq;
  int                mCredit;
  int                mSend;
  int                mRet;
  int                mPtr;
  bit                mErr;
  logic [NumReq-1:0] reqPend;
  logic [NumReq-1:0] w;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mBusy   = 1'b0;
    mReq    = -1;
    mCredit = 0;
    mSend   = NumCredits;
    mRet    = 0;
    mPtr    = 0;
    mErr    = 1'b0;
  endtask

  // One clock cycle: apply inputs, predict this cycle's status and any packet
  // accepted at the coming edge, then advance the model past that edge.
  task automatic driveCycle(input logic [NumReq-1:0] want, input bit ready,
                            input bit rcvV, input int rcv, input bit cons);
    bit hs;
    bit dataHs;
    int sendEff;
    int retEff;
    int pick;
    int newSend;
    @(posedge clk_i); #1;
    reqPend            = reqPend | want;
    req_valid_i        = reqPend;
    pkt_ready_i        = ready;
    rcv_credit_valid_i = rcvV;
    rcv_credit_i       = credit_t'(rcv);
    consumed_i         = cons;

    statQ.push_back('{valid: mBusy, send: mSend, err: mErr});
    hs     = mBusy && ready;
    dataHs = hs && (mReq >= 0);
    if (hs) begin
      if (mReq < 0) expQ.push_back('{tag: int'(TagIdle), sel: 4'b0, credit: mCredit});
      else          expQ.push_back('{tag: int'(TagAW) + mReq, sel: 4'(1 << mReq), credit: mCredit});
    end

    // Pools as seen by a new offer: the departing packet is settled, this
    // cycle's incoming credits and consumed pulses are not visible yet.
    sendEff = mSend - (dataHs ? 1 : 0);
    retEff  = mRet - (hs ? mCredit : 0);
    if (dataHs) begin
      reqPend[mReq] = 1'b0;
      mPtr = (mReq + 1) % NumReq;
    end

    if (!mBusy || hs) begin
      pick = -1;
      if (sendEff > 0) begin
        for (int k = 0; k < NumReq; k++) begin
          int j;
          j = (mPtr + k) % NumReq;
          if (pick < 0 && reqPend[j]) pick = j;
        end
      end
      if (pick >= 0) begin
        mBusy = 1'b1; mReq = pick; mCredit = retEff;
      end else if (retEff >= int'(ForceCreditThresh)) begin
        mBusy = 1'b1; mReq = -1; mCredit = retEff;
      end else begin
        mBusy = 1'b0;
      end
    end

    newSend = sendEff + (rcvV ? rcv : 0);
    if (newSend > int'(NumCredits)) begin
      newSend = NumCredits;
      mErr = 1'b1;
    end
    mSend = newSend;
    mRet  = retEff + (cons ? 1 : 0);
    if (mRet > int'(NumCredits)) mRet = NumCredits;
  endtask

  task automatic doReset();
    @(posedge clk_i); #1;
    rst_ni             = 1'b0;
    req_valid_i        = '0;
    pkt_ready_i        = 1'b0;
    rcv_credit_valid_i = 1'b0;
    rcv_credit_i       = '0;
    consumed_i         = 1'b0;
    reqPend            = '0;
    modelReset();
    expQ.delete();
    statQ.delete();
    @(negedge clk_i);
    chk("rst_pkt_valid", int'(pkt_valid_o), 0);
    chk("rst_req_ready", int'(req_ready_o), 0);
    chk("rst_pkt_sel", int'(pkt_sel_o), 0);
    chk("rst_pkt_tag", int'(pkt_tag_o), int'(TagIdle));
    chk("rst_pkt_credit", int'(pkt_credit_o), 0);
    chk("rst_credit_err", int'(credit_err_o), 0);
    chk("rst_credits_avail", int'(credits_avail_o), int'(NumCredits));
  endtask

  task automatic releaseReset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // Monitor: per-cycle status plus every accepted packet.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (statQ.size() > 0) begin
        monStat = statQ.pop_front();
        chk("pkt_valid", int'(pkt_valid_o), int'(monStat.valid));
        chk("credits_avail", int'(credits_avail_o), monStat.send);
        chk("credit_err", int'(credit_err_o), int'(monStat.err));
      end
      if (pkt_valid_o && pkt_ready_i) begin
        chk("pkt_expected", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          monPkt = expQ.pop_front();
          chk("pkt_tag", int'(pkt_tag_o), monPkt.tag);
          chk("pkt_sel", int'(pkt_sel_o), int'(monPkt.sel));
          chk("pkt_credit", int'(pkt_credit_o), monPkt.credit);
          chk("req_ready", int'(req_ready_o), int'(monPkt.sel));
        end
      end else begin
        chk("req_ready_idle", int'(req_ready_o), 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni             = 1'b0;
    req_valid_i        = '0;
    pkt_ready_i        = 1'b0;
    rcv_credit_valid_i = 1'b0;
    rcv_credit_i       = '0;
    consumed_i         = 1'b0;
    reqPend            = '0;
    modelReset();

    doReset();
    releaseReset();

    // All requesters busy: AW,W,AR,R twice, then out of credits.
    repeat (12) driveCycle(4'hF, 1'b1, 1'b0, 0, 1'b0);

    // Three credits back: exactly three more data packets.
    driveCycle(4'h0, 1'b1, 1'b1, 3, 1'b0);
    repeat (8) driveCycle(4'h0, 1'b1, 1'b0, 0, 1'b0);

    // Seven consumed entries force one credit-only packet carrying 7.
    repeat (7) driveCycle(4'h0, 1'b1, 1'b0, 0, 1'b1);
    repeat (4) driveCycle(4'h0, 1'b1, 1'b0, 0, 1'b0);

    // One credit, stall the offer 5 cycles while consuming, then accept it
    // while the peer returns 2 credits in the same cycle.
    driveCycle(4'h0, 1'b1, 1'b1, 1, 1'b0);
    driveCycle(4'h0, 1'b1, 1'b0, 0, 1'b0);
    repeat (5) driveCycle(4'h0, 1'b0, 1'b0, 0, 1'b1);
    driveCycle(4'h0, 1'b1, 1'b1, 2, 1'b0);
    repeat (3) driveCycle(4'h0, 1'b1, 1'b0, 0, 1'b0);

    // Randomized traffic, stalls, credit returns and consumption.
    for (int c = 0; c < 2000; c++) begin
      w = 4'($urandom) & 4'($urandom);
      driveCycle(w, ($urandom % 4) != 0, ($urandom % 3) == 0,
                 int'($urandom_range(0, NumCredits - mSend)), ($urandom % 3) == 0);
    end

    // Refill, stall an offer and reset in the middle of it.
    driveCycle(4'h0, 1'b0, 1'b1, NumCredits - mSend, 1'b0);
    repeat (3) driveCycle(4'hF, 1'b0, 1'b0, 0, 1'b0);
    doReset();
    releaseReset();

    // Over-return at full credits: clamp and sticky error.
    driveCycle(4'h0, 1'b1, 1'b1, 1, 1'b0);
    repeat (4) driveCycle(4'h0, 1'b1, 1'b0, 0, 1'b0);
    doReset();

    chk("scoreboard_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
